// File: rtl/word_align_ctrl.sv
// Word alignment controller: hunts for a periodic sync word on the slipper's
// output stream, steps slip_amount until it appears, and tracks lock/unlock.
module word_align_ctrl #(
  parameter int unsigned         DataBits    = 32,
  parameter int unsigned         MaxSlip     = 7,
  parameter logic [DataBits-1:0] SyncWord    = 32'hA5C3_0FF0,
  parameter logic [DataBits-1:0] SyncMask    = '1,
  parameter int unsigned         SyncPeriod  = 16,
  parameter int unsigned         LockCount   = 4,
  parameter int unsigned         UnlockCount = 3,
  parameter int unsigned         SettleWords = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mon_valid,
  input  logic                               mon_ready,
  input  logic [DataBits-1:0]                mon_data,
  input  logic                               realign,
  output logic [$clog2(MaxSlip+1)-1:0]       slip_amount,
  output logic                               locked,
  output logic                               sync_found,
  output logic [1:0]                         state
);

  localparam int unsigned SlipW = $clog2(MaxSlip + 1);
  localparam int unsigned PosW  = $clog2(SyncPeriod);
  localparam int unsigned HitW  = $clog2(LockCount + 1);
  localparam int unsigned MissW = $clog2(UnlockCount + 1);
  localparam int unsigned SetW  = $clog2(SettleWords + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SlipW-1:0] slip_q, slip_d;
  logic             locked_q, locked_d;
  logic             sync_q, sync_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [PosW-1:0]  hunt_q, hunt_d;
  logic [HitW-1:0]  hits_q, hits_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic             accept, hit, bump;

  // Passive tap: a word exists only on a cycle where mon_valid and mon_ready
  // are both high; valid without ready is a stall and is neither counted nor compared.
  assign accept = mon_valid & mon_ready;
  assign hit    = (mon_data & SyncMask) == (SyncWord & SyncMask);

  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    locked_d = locked_q;
    sync_d   = 1'b0;
    pos_d    = pos_q;
    hunt_d   = hunt_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    settle_d = settle_q;
    bump     = 1'b0;

    if (realign) begin
      bump = 1'b1;
    end else if (accept) begin
      unique case (state_q)
        ST_HUNT: begin
          if (hit) begin
            state_d = ST_VERIFY;
            pos_d   = '0;
            hits_d  = HitW'(1);
            sync_d  = 1'b1;
          end else if (hunt_q == PosW'(SyncPeriod - 1)) begin
            bump = 1'b1;
          end else begin
            hunt_d = hunt_q + PosW'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_q == SetW'(SettleWords - 1)) begin
            state_d  = ST_HUNT;
            settle_d = '0;
            hunt_d   = '0;
          end else begin
            settle_d = settle_q + SetW'(1);
          end
        end
        default: begin
          // VERIFY and LOCKED share the position schedule; only the wrap word is compared.
          if (pos_q == PosW'(SyncPeriod - 1)) begin
            pos_d = '0;
            if (state_q == ST_VERIFY) begin
              if (!hit) begin
                bump = 1'b1;
              end else begin
                sync_d = 1'b1;
                if (hits_q >= HitW'(LockCount - 1)) begin
                  state_d  = ST_LOCKED;
                  locked_d = 1'b1;
                  miss_d   = '0;
                  hits_d   = '0;
                end else begin
                  hits_d = hits_q + HitW'(1);
                end
              end
            end else if (hit) begin
              miss_d = '0;
              sync_d = 1'b1;
            end else if (miss_q == MissW'(UnlockCount - 1)) begin
              state_d  = ST_HUNT;
              locked_d = 1'b0;
              miss_d   = '0;
              hunt_d   = '0;
            end else begin
              miss_d = miss_q + MissW'(1);
            end
          end else begin
            pos_d = pos_q + PosW'(1);
          end
        end
      endcase
    end

    // A bump overrides whatever the word processing decided this cycle.
    if (bump) begin
      slip_d   = (slip_q == SlipW'(MaxSlip)) ? '0 : slip_q + SlipW'(1);
      state_d  = ST_SETTLE;
      locked_d = 1'b0;
      sync_d   = 1'b0;
      pos_d    = '0;
      hunt_d   = '0;
      hits_d   = '0;
      miss_d   = '0;
      settle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_HUNT;
      slip_q   <= '0;
      locked_q <= 1'b0;
      sync_q   <= 1'b0;
      pos_q    <= '0;
      hunt_q   <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      slip_q   <= slip_d;
      locked_q <= locked_d;
      sync_q   <= sync_d;
      pos_q    <= pos_d;
      hunt_q   <= hunt_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      settle_q <= settle_d;
    end
  end

  assign slip_amount = slip_q;
  assign locked      = locked_q;
  assign sync_found  = sync_q;
  assign state       = state_q;

endmodule
